// File: rtl/shift_ctrl_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// shift_ctrl_pkg: shared types and constants for the shifter control front end
// Rev 1.0
// ----------------------------------------------------------------------------
package shift_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_e;

  localparam int SPEED_W    = 2;
  localparam int NUM_SPEEDS = 4;

  localparam logic               DIR_RST   = 1'b0;
  localparam logic [SPEED_W-1:0] SPEED_RST = '0;

endpackage
`default_nettype wire

// File: rtl/shift_ctrl_frontend_btn_conditioner.sv
`default_nettype none
// ----------------------------------------------------------------------------
// btn_conditioner: 2-FF sync, sampled debounce and single press pulse per button
// Rev 1.0
// ----------------------------------------------------------------------------
module btn_conditioner #(
  parameter int DB_DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic sample_tick,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  logic [1:0]          r_sync;
  logic [DB_DEPTH-1:0] r_shift;
  logic                r_level;
  logic                r_press;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync  <= '0;
      r_shift <= '0;
      r_level <= 1'b0;
      r_press <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], btn_raw};
      if (sample_tick) begin
        r_shift <= {r_shift[DB_DEPTH-2:0], r_sync[1]};
      end
      // press rises together with the level, so it lasts exactly one cycle
      r_press <= 1'b0;
      if (&r_shift) begin
        r_level <= 1'b1;
        r_press <= ~r_level;
      end else if (~|r_shift) begin
        r_level <= 1'b0;
      end
    end
  end

  assign level = r_level;
  assign press = r_press;

endmodule
`default_nettype wire

// File: rtl/shift_ctrl_frontend.sv
`default_nettype none
// ----------------------------------------------------------------------------
// shift_ctrl_frontend: push-buttons -> en / dir / step / speed for the LED shifter
// Rev 1.0
// ----------------------------------------------------------------------------
module shift_ctrl_frontend
  import shift_ctrl_pkg::*;
#(
  parameter int DB_TICK_W   = 16,
  parameter int DB_DEPTH    = 4,
  parameter int STEP_BASE_W = 22
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_start,
  input  logic               btn_dir,
  input  logic               btn_speed,
  output logic               en,
  output logic               dir,
  output logic               step,
  output logic [SPEED_W-1:0] speed
);

  localparam logic [STEP_BASE_W-1:0] c_STEP_ALL_ONES = '1;

  logic [DB_TICK_W-1:0]   r_tick_cnt;
  logic                   w_sample_tick;
  logic [2:0]             w_raw;
  logic [2:0]             w_level;
  logic [2:0]             w_press;
  logic                   w_start_press;
  logic                   w_dir_press;
  logic                   w_speed_press;

  state_e                 r_state;
  logic                   r_en;
  logic                   r_dir;
  logic                   r_step;
  logic [SPEED_W-1:0]     r_speed;
  logic [STEP_BASE_W-1:0] r_step_cnt;
  logic [STEP_BASE_W-1:0] w_step_last;
  logic                   w_step_term;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + 1'b1;
    end
  end

  assign w_sample_tick = &r_tick_cnt;
  assign w_raw         = {btn_speed, btn_dir, btn_start};

  for (genvar gi = 0; gi < 3; gi++) begin : g_btn
    btn_conditioner #(
      .DB_DEPTH (DB_DEPTH)
    ) u_cond (
      .clk         (clk),
      .rst         (rst),
      .sample_tick (w_sample_tick),
      .btn_raw     (w_raw[gi]),
      .level       (w_level[gi]),
      .press       (w_press[gi])
    );
  end

  // A press pulse only ever coincides with a settled high level
  assign w_start_press = w_press[0] & w_level[0];
  assign w_dir_press   = w_press[1] & w_level[1];
  assign w_speed_press = w_press[2] & w_level[2];

  // Period 2^(STEP_BASE_W - speed): terminal count is the low bits all ones
  assign w_step_last = c_STEP_ALL_ONES >> r_speed;
  assign w_step_term = (r_step_cnt == w_step_last);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_en       <= 1'b0;
      r_dir      <= DIR_RST;
      r_speed    <= SPEED_RST;
      r_step     <= 1'b0;
      r_step_cnt <= '0;
    end else begin
      r_step <= 1'b0;

      if (w_dir_press) begin
        r_dir <= ~r_dir;
      end

      unique case (r_state)
        IDLE: if (w_start_press) begin
          r_state <= RUN;
          r_en    <= 1'b1;
        end
        RUN: if (w_start_press) begin
          r_state <= PAUSE;
          r_en    <= 1'b0;
        end
        PAUSE: if (w_start_press) begin
          r_state <= RUN;
          r_en    <= 1'b1;
        end
        default: begin
          r_state <= IDLE;
          r_en    <= 1'b0;
        end
      endcase

      // Speed change overrides a coincident terminal count
      if (w_speed_press) begin
        r_speed    <= r_speed + 1'b1;
        r_step_cnt <= '0;
      end else if (r_state == RUN) begin
        if (w_step_term) begin
          r_step     <= 1'b1;
          r_step_cnt <= '0;
        end else begin
          r_step_cnt <= r_step_cnt + 1'b1;
        end
      end else if (r_state == IDLE) begin
        r_step_cnt <= '0;
      end
    end
  end

  assign en    = r_en;
  assign dir   = r_dir;
  assign step  = r_step;
  assign speed = r_speed;

endmodule
`default_nettype wire

// File: tb/tb_shift_ctrl_frontend.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_shift_ctrl_frontend: scoreboard bench for step cadence, FSM, dir and speed
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_shift_ctrl_frontend;
  import shift_ctrl_pkg::*;

  localparam int BASE_P = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_start = 1'b0;
  logic btn_dir = 1'b0;
  logic btn_speed = 1'b0;
  logic en, dir, step;
  logic [SPEED_W-1:0] speed;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int step_cnt = 0, en_rise = 0, en_fall = 0, spd_chg = 0, dir_chg = 0;
  int ref_cyc = 0, fall_cyc = 0;
  logic en_prev = 1'b0, dir_prev = 1'b0;
  logic [SPEED_W-1:0] speed_prev = '0;
  int exp_gap[$];

  shift_ctrl_frontend #(
    .DB_TICK_W   (2),
    .DB_DEPTH    (4),
    .STEP_BASE_W (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_start (btn_start),
    .btn_dir   (btn_dir),
    .btn_speed (btn_speed),
    .en        (en),
    .dir       (dir),
    .step      (step),
    .speed     (speed)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: expected gaps (in cycles) since the last counter restart
  always @(negedge clk) begin : mon
    int e;
    if (step === 1'b1) begin
      if (exp_gap.size() != 0) begin
        e = exp_gap.pop_front();
        n_vec++;
        if (cyc - ref_cyc != e) begin
          n_err++;
          $display("FAIL step_gap: got %0d cycles, expected %0d (cycle %0d)", cyc - ref_cyc, e, cyc);
        end
      end
      step_cnt++;
    end
    if (step === 1'b1 && en === 1'b0 && en_prev === 1'b0) begin
      n_err++;
      $display("FAIL step_outside_run: step=1 with en=0 at cycle %0d, expected step=0", cyc);
    end
    if (en === 1'b1 && en_prev === 1'b0) en_rise++;
    if (en === 1'b0 && en_prev === 1'b1) begin
      en_fall++;
      fall_cyc = cyc;
    end
    if (dir !== dir_prev) dir_chg++;
    if (speed !== speed_prev) spd_chg++;
    if (step === 1'b1 || (en === 1'b1 && en_prev === 1'b0) || speed !== speed_prev) ref_cyc = cyc;
    en_prev    = en;
    dir_prev   = dir;
    speed_prev = speed;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input int which);
    case (which)
      0:       btn_start = 1'b1;
      1:       btn_dir   = 1'b1;
      default: btn_speed = 1'b1;
    endcase
    tick(40);
    btn_start = 1'b0;
    btn_dir   = 1'b0;
    btn_speed = 1'b0;
    tick(40);
  endtask

  task automatic drain(input int limit, output bit ok);
    int t;
    t = 0;
    while (exp_gap.size() != 0 && t < limit) begin
      tick(1);
      t++;
    end
    ok = (exp_gap.size() == 0);
    exp_gap.delete();
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick(3);
    n_vec++; if (en !== 1'b0)    begin n_err++; $display("FAIL reset_en: got %b, expected 0", en); end
    n_vec++; if (dir !== 1'b0)   begin n_err++; $display("FAIL reset_dir: got %b, expected 0", dir); end
    n_vec++; if (speed !== 2'd0) begin n_err++; $display("FAIL reset_speed: got %0d, expected 0", speed); end
    n_vec++; if (step !== 1'b0)  begin n_err++; $display("FAIL reset_step: got %b, expected 0", step); end
    rst = 1'b0;
    tick(200);
    n_vec++;
    if (en !== 1'b0 || dir !== 1'b0 || speed !== 2'd0 || step_cnt != 0 || en_rise != 0) begin
      n_err++;
      $display("FAIL idle_hold: en=%b dir=%b speed=%0d steps=%0d, expected 0 0 0 0", en, dir, speed, step_cnt);
    end
  endtask

  task automatic test_bounce;
    int r0, f0;
    r0 = en_rise;
    // Square wave whose samples alternate, so no level can settle
    for (int i = 0; i < 20; i++) begin
      btn_start = ((i / 4) % 2 == 0);
      tick(1);
    end
    btn_start = 1'b0;
    tick(60);
    n_vec++;
    if (en !== 1'b0 || en_rise != r0) begin
      n_err++;
      $display("FAIL bounce_only: en=%b rises=%0d, expected en=0 rises=0", en, en_rise - r0);
    end
    for (int i = 0; i < 20; i++) begin
      btn_start = ~btn_start;
      tick(1);
    end
    btn_start = 1'b1;
    tick(40);
    f0 = en_fall;
    for (int i = 0; i < 20; i++) begin
      btn_start = ~btn_start;
      tick(1);
    end
    btn_start = 1'b0;
    tick(40);
    n_vec++;
    if (en_rise - r0 != 1 || en !== 1'b1) begin
      n_err++;
      $display("FAIL bounce_press: en=%b rises=%0d, expected en=1 rises=1", en, en_rise - r0);
    end
    n_vec++;
    if (en_fall != f0) begin
      n_err++;
      $display("FAIL release_bounce: extra falls=%0d, expected 0", en_fall - f0);
    end
  endtask

  task automatic test_rates;
    bit ok;
    int s0, t, p;
    repeat (3) exp_gap.push_back(BASE_P);
    drain(200, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL rate0_drain: steps missing, expected 3 steps of %0d", BASE_P); end
    for (int k = 1; k <= NUM_SPEEDS; k++) begin
      s0 = spd_chg;
      t  = 0;
      btn_speed = 1'b1;
      while (spd_chg == s0 && t < 60) begin
        tick(1);
        t++;
      end
      n_vec++;
      if (speed !== 2'(k % NUM_SPEEDS)) begin
        n_err++;
        $display("FAIL speed_step%0d: got %0d, expected %0d", k, speed, k % NUM_SPEEDS);
      end
      p = BASE_P >> (k % NUM_SPEEDS);
      repeat (3) exp_gap.push_back(p);
      tick(40);
      btn_speed = 1'b0;
      tick(40);
      drain(200, ok);
      n_vec++; if (!ok) begin n_err++; $display("FAIL rate_drain%0d: steps missing, expected 3 steps of %0d", k, p); end
    end
  endtask

  task automatic test_pause_resume;
    int f0, r0, t, c, sc;
    bit ok;
    f0 = en_fall;
    t  = 0;
    btn_start = 1'b1;
    while (en_fall == f0 && t < 60) begin
      tick(1);
      t++;
    end
    n_vec++; if (en_fall == f0) begin n_err++; $display("FAIL pause_timeout: en=%b, expected 0", en); end
    c = fall_cyc - ref_cyc;
    n_vec++;
    if (c < 0 || c >= BASE_P) begin
      n_err++;
      $display("FAIL pause_count: frozen count %0d, expected 0..%0d", c, BASE_P - 1);
      c = 0;
    end
    sc = step_cnt;
    tick(40);
    btn_start = 1'b0;
    tick(60);
    n_vec++;
    if (step_cnt != sc || en !== 1'b0) begin
      n_err++;
      $display("FAIL paused_hold: steps=%0d en=%b, expected 0 steps en=0", step_cnt - sc, en);
    end
    r0 = en_rise;
    t  = 0;
    btn_start = 1'b1;
    while (en_rise == r0 && t < 60) begin
      tick(1);
      t++;
    end
    n_vec++; if (en_rise == r0) begin n_err++; $display("FAIL resume_timeout: en=%b, expected 1", en); end
    exp_gap.push_back(BASE_P - c);
    exp_gap.push_back(BASE_P);
    exp_gap.push_back(BASE_P);
    tick(40);
    btn_start = 1'b0;
    tick(40);
    drain(200, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL resume_drain: steps missing, expected first after %0d", BASE_P - c); end
  endtask

  task automatic test_dir;
    int d0, t;
    logic exp_dir;
    bit ok;
    n_vec++; if (dir !== 1'b0) begin n_err++; $display("FAIL dir_start: got %b, expected 0", dir); end
    exp_dir = 1'b0;
    repeat (15) exp_gap.push_back(BASE_P);
    for (int k = 0; k < 3; k++) begin
      d0 = dir_chg;
      t  = 0;
      exp_dir = ~exp_dir;
      btn_dir = 1'b1;
      while (dir_chg == d0 && t < 60) begin
        tick(1);
        t++;
      end
      n_vec++;
      if (dir !== exp_dir) begin
        n_err++;
        $display("FAIL dir_toggle%0d: got %b, expected %b", k, dir, exp_dir);
      end
      tick(40);
      btn_dir = 1'b0;
      tick(40);
    end
    drain(300, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL dir_cadence: steps missing, expected gap %0d", BASE_P); end
    d0 = dir_chg;
    btn_dir = 1'b1;
    tick(100);
    btn_dir = 1'b0;
    tick(40);
    n_vec++;
    if (dir_chg - d0 != 1 || dir !== 1'b0) begin
      n_err++;
      $display("FAIL dir_held: toggles=%0d dir=%b, expected 1 toggle dir=0", dir_chg - d0, dir);
    end
  endtask

  task automatic test_reset_mid_run;
    int sc, r0, t;
    bit ok;
    press(2);
    press(2);
    press(1);
    n_vec++;
    if (speed !== 2'd2 || dir !== 1'b1 || en !== 1'b1) begin
      n_err++;
      $display("FAIL pre_reset: speed=%0d dir=%b en=%b, expected 2 1 1", speed, dir, en);
    end
    exp_gap.delete();
    rst = 1'b1;
    tick(1);
    n_vec++;
    if (en !== 1'b0 || dir !== 1'b0 || speed !== 2'd0 || step !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset: en=%b dir=%b speed=%0d step=%b, expected 0 0 0 0", en, dir, speed, step);
    end
    rst = 1'b0;
    sc = step_cnt;
    tick(100);
    n_vec++;
    if (step_cnt != sc || en !== 1'b0) begin
      n_err++;
      $display("FAIL post_reset_idle: steps=%0d en=%b, expected 0 steps en=0", step_cnt - sc, en);
    end
    r0 = en_rise;
    t  = 0;
    btn_start = 1'b1;
    while (en_rise == r0 && t < 60) begin
      tick(1);
      t++;
    end
    n_vec++; if (en_rise == r0) begin n_err++; $display("FAIL restart_timeout: en=%b, expected 1", en); end
    exp_gap.push_back(BASE_P);
    exp_gap.push_back(BASE_P);
    tick(40);
    btn_start = 1'b0;
    tick(40);
    drain(200, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL restart_drain: steps missing, expected gap %0d", BASE_P); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_bounce();
    test_rates();
    test_pause_resume();
    test_dir();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
